// File: rtl/cc_level_scroller.sv
// cc_level_scroller: level sequencer and 8x8 playfield scroller fed by the level data handler
module cc_level_scroller #(
  parameter int DATAWIDTH       = 8,
  parameter int CURRENTLEVEL_DW = 3,
  parameter int PROGRESS_DW     = 5,
  parameter int NUM_LEVELS      = 6,
  parameter int LEN_L1          = 8,
  parameter int LEN_L2          = 10,
  parameter int LEN_L3          = 8,
  parameter int LEN_L4          = 15,
  parameter int LEN_L5          = 8,
  parameter int LEN_L6          = 20,
  parameter int GAP_ROWS        = 8
) (
  input  logic                       CC_LEVEL_SCROLLER_CLOCK_50,
  input  logic                       CC_LEVEL_SCROLLER_RESET_InHigh,
  input  logic                       CC_LEVEL_SCROLLER_Start_In,
  input  logic                       CC_LEVEL_SCROLLER_ScrollTick_In,
  input  logic                       CC_LEVEL_SCROLLER_Pause_In,
  input  logic [DATAWIDTH-1:0]       CC_LEVEL_SCROLLER_LevelData_InBus,
  output logic [CURRENTLEVEL_DW-1:0] CC_LEVEL_SCROLLER_CurrentLvl_OutBus,
  output logic [PROGRESS_DW-1:0]     CC_LEVEL_SCROLLER_LvlProgress_OutBus,
  output logic [DATAWIDTH*8-1:0]     CC_LEVEL_SCROLLER_Matrix_OutBus,
  output logic                       CC_LEVEL_SCROLLER_LevelDone_Out,
  output logic                       CC_LEVEL_SCROLLER_GameWin_Out
);
  typedef enum logic [1:0] {IDLE, RUN, GAP, WIN} stateType;
  stateType state;
  logic [PROGRESS_DW-1:0] gapCnt;
  logic [PROGRESS_DW-1:0] curLen;
  logic tickOk;
  logic startOk;
  logic [CURRENTLEVEL_DW-1:0] lvl;
  logic [PROGRESS_DW-1:0] prog;
  logic [DATAWIDTH*8-1:0] matrix;
  assign lvl    = CC_LEVEL_SCROLLER_CurrentLvl_OutBus;
  assign prog   = CC_LEVEL_SCROLLER_LvlProgress_OutBus;
  assign matrix = CC_LEVEL_SCROLLER_Matrix_OutBus;
  // row count of the level currently being scrolled
  always_comb curLen = (lvl == 3'd1) ? PROGRESS_DW'(LEN_L1) :
                       (lvl == 3'd2) ? PROGRESS_DW'(LEN_L2) :
                       (lvl == 3'd3) ? PROGRESS_DW'(LEN_L3) :
                       (lvl == 3'd4) ? PROGRESS_DW'(LEN_L4) :
                       (lvl == 3'd5) ? PROGRESS_DW'(LEN_L5) : PROGRESS_DW'(LEN_L6);
  assign tickOk  = CC_LEVEL_SCROLLER_ScrollTick_In & ~CC_LEVEL_SCROLLER_Pause_In;
  assign startOk = CC_LEVEL_SCROLLER_Start_In & ((state == IDLE) | (state == WIN));
  // level/gap sequencing and playfield shifting; start beats a same-cycle tick
  always_ff @(posedge CC_LEVEL_SCROLLER_CLOCK_50) begin
    if (CC_LEVEL_SCROLLER_RESET_InHigh) begin
      state                                <= IDLE;
      gapCnt                               <= '0;
      CC_LEVEL_SCROLLER_CurrentLvl_OutBus  <= '0;
      CC_LEVEL_SCROLLER_LvlProgress_OutBus <= '0;
      CC_LEVEL_SCROLLER_Matrix_OutBus      <= '0;
      CC_LEVEL_SCROLLER_LevelDone_Out      <= 1'b0;
      CC_LEVEL_SCROLLER_GameWin_Out        <= 1'b0;
    end else begin
      CC_LEVEL_SCROLLER_LevelDone_Out <= 1'b0;
      if (startOk) begin
        state                                <= RUN;
        gapCnt                               <= '0;
        CC_LEVEL_SCROLLER_CurrentLvl_OutBus  <= CURRENTLEVEL_DW'(1);
        CC_LEVEL_SCROLLER_LvlProgress_OutBus <= PROGRESS_DW'(1);
        CC_LEVEL_SCROLLER_Matrix_OutBus      <= '0;
        CC_LEVEL_SCROLLER_GameWin_Out        <= 1'b0;
      end else if (tickOk && state == RUN) begin
        CC_LEVEL_SCROLLER_Matrix_OutBus <= {CC_LEVEL_SCROLLER_LevelData_InBus, matrix[DATAWIDTH*8-1:DATAWIDTH]};
        if (prog == curLen) begin
          state                                <= GAP;
          gapCnt                               <= '0;
          CC_LEVEL_SCROLLER_LvlProgress_OutBus <= '0;
          CC_LEVEL_SCROLLER_LevelDone_Out      <= 1'b1;
        end else begin
          CC_LEVEL_SCROLLER_LvlProgress_OutBus <= prog + 1'b1;
        end
      end else if (tickOk && state == GAP) begin
        CC_LEVEL_SCROLLER_Matrix_OutBus <= {{DATAWIDTH{1'b0}}, matrix[DATAWIDTH*8-1:DATAWIDTH]};
        gapCnt <= gapCnt + 1'b1;
        if (gapCnt == PROGRESS_DW'(GAP_ROWS - 1)) begin
          if (lvl == CURRENTLEVEL_DW'(NUM_LEVELS)) begin
            state                         <= WIN;
            CC_LEVEL_SCROLLER_GameWin_Out <= 1'b1;
          end else begin
            state                                <= RUN;
            CC_LEVEL_SCROLLER_CurrentLvl_OutBus  <= lvl + 1'b1;
            CC_LEVEL_SCROLLER_LvlProgress_OutBus <= PROGRESS_DW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cc_level_scroller.sv
// tb_cc_level_scroller: scoreboard bench with a position-based game model and a stub data handler
module tb_cc_level_scroller;
  logic clk = 1'b0;
  logic rst, start, tick, pause;
  logic [7:0] levelData;
  logic [2:0] lvlO;
  logic [4:0] progO;
  logic [63:0] matO;
  logic doneO, winO;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [2:0] lvl;
    logic [4:0] prog;
    logic [63:0] mat;
    logic done;
    logic win;
  } expType;
  expType sb[$];
  int lens[1:6] = '{8, 10, 8, 15, 8, 20};
  bit mActive = 0;
  int mPos = 0;
  logic [63:0] mMat = '0;
  always #5 clk = ~clk;
  cc_level_scroller dut (
    .CC_LEVEL_SCROLLER_CLOCK_50(clk),
    .CC_LEVEL_SCROLLER_RESET_InHigh(rst),
    .CC_LEVEL_SCROLLER_Start_In(start),
    .CC_LEVEL_SCROLLER_ScrollTick_In(tick),
    .CC_LEVEL_SCROLLER_Pause_In(pause),
    .CC_LEVEL_SCROLLER_LevelData_InBus(levelData),
    .CC_LEVEL_SCROLLER_CurrentLvl_OutBus(lvlO),
    .CC_LEVEL_SCROLLER_LvlProgress_OutBus(progO),
    .CC_LEVEL_SCROLLER_Matrix_OutBus(matO),
    .CC_LEVEL_SCROLLER_LevelDone_Out(doneO),
    .CC_LEVEL_SCROLLER_GameWin_Out(winO)
  );
  // stand-in for the level data handler: combinational row lookup
  function automatic logic [7:0] rom(input logic [2:0] l, input logic [4:0] p);
    if (p == 0) return 8'h00;
    if (l == 1 && p == 1) return 8'hFF;
    if (l == 2 && p == 1) return 8'h20;
    return {l, p} ^ 8'h5A;
  endfunction
  assign levelData = rom(lvlO, progO);
  // map ticks-since-start to level/progress/gap/win
  task automatic decode(input int pos, output int l, output int p, output bit g, output bit w);
    int r = pos;
    w = 0;
    for (int i = 1; i <= 6; i++) begin
      if (r < lens[i]) begin l = i; p = r + 1; g = 0; return; end
      r -= lens[i];
      if (r < 8) begin l = i; p = 0; g = 1; return; end
      r -= 8;
    end
    l = 6; p = 0; g = 0; w = 1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic t, input logic p);
    int l, pr, l2, p2;
    bit g, w, g2, w2;
    expType e;
    e.done = 0;
    if (r) begin
      mActive = 0; mPos = 0; mMat = '0;
    end else begin
      decode(mPos, l, pr, g, w);
      if (s && (!mActive || w)) begin
        mActive = 1; mPos = 0; mMat = '0;
      end else if (mActive && !w && t && !p) begin
        mMat = {g ? 8'h00 : rom(3'(l), 5'(pr)), mMat[63:8]};
        e.done = !g && pr == lens[l];
        mPos++;
      end
    end
    decode(mPos, l2, p2, g2, w2);
    e.lvl = mActive ? 3'(l2) : 3'd0;
    e.prog = mActive ? 5'(p2) : 5'd0;
    e.mat = mMat;
    e.win = mActive && w2;
    sb.push_back(e);
    rst = r; start = s; tick = t; pause = p;
    @(posedge clk);
    #1;
    rst = 0; start = 0; tick = 0; pause = 0;
    e = sb.pop_front();
    chk("lvl", 64'(lvlO), 64'(e.lvl));
    chk("prog", 64'(progO), 64'(e.prog));
    chk("matrix", matO, e.mat);
    chk("done", 64'(doneO), 64'(e.done));
    chk("win", 64'(winO), 64'(e.win));
  endtask
  initial begin
    int dones;
    logic [2:0] sl;
    logic [4:0] sp;
    logic [63:0] sm;
    rst = 1; start = 0; tick = 0; pause = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_all", {lvlO, progO, matO, doneO, winO}, '0);
    step(0, 0, 1, 0);
    chk("idle_tick_ignored", matO, 64'h0);
    // T1
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t1_lvl", 64'(lvlO), 64'd1);
    chk("t1_prog", 64'(progO), 64'd2);
    chk("t1_matrix", matO, 64'hFF00_0000_0000_0000);
    // T2 (start ignored while running)
    step(0, 1, 0, 0);
    chk("t2_start_in_run_ignored", 64'(progO), 64'd2);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin step(0, 0, 1, 0); dones += int'(doneO); end
    step(0, 0, 0, 0);
    dones += int'(doneO);
    chk("t2_done_count", 64'(dones), 64'd1);
    chk("t2_prog_gap", 64'(progO), 64'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("t2_lvl2", 64'(lvlO), 64'd2);
    chk("t2_prog1", 64'(progO), 64'd1);
    chk("t2_matrix_clear", matO, 64'h0);
    step(0, 0, 1, 0);
    chk("t2_row0", 64'(matO[63:56]), 64'h20);
    // T3
    sl = lvlO; sp = progO; sm = matO;
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    chk("t3_lvl_hold", 64'(lvlO), 64'(sl));
    chk("t3_prog_hold", 64'(progO), 64'(sp));
    chk("t3_matrix_hold", matO, sm);
    step(0, 0, 1, 0);
    chk("t3_prog_adv", 64'(progO), 64'(sp + 5'd1));
    // T4
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    dones = 0;
    for (int i = 0; i < 117; i++) begin step(0, 0, 1, 0); dones += int'(doneO); end
    step(0, 0, 0, 0);
    dones += int'(doneO);
    chk("t4_done_count", 64'(dones), 64'd6);
    chk("t4_win", 64'(winO), 64'd1);
    sm = matO;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("t4_win_hold", matO, sm);
    step(0, 1, 0, 0);
    chk("t4_restart", {lvlO, progO, matO, winO}, {3'd1, 5'd1, 64'h0, 1'b0});
    // T5: 50 ticks reach level 4 progress 1, 6 more reach progress 7
    for (int i = 0; i < 56; i++) step(0, 0, 1, 0);
    chk("t5_lvl4", 64'(lvlO), 64'd4);
    chk("t5_prog7", 64'(progO), 64'd7);
    step(1, 0, 1, 0);
    chk("t5_reset_all", {lvlO, progO, matO, doneO, winO}, '0);
    step(0, 0, 1, 0);
    chk("t5_idle_hold", {lvlO, progO, matO}, '0);
    // T6
    step(0, 1, 1, 0);
    chk("t6_start_only", {lvlO, progO, matO}, {3'd1, 5'd1, 64'h0});
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
